word_serializer: RTL and testbench
==================================

Name: word_serializer

Overview:
- Width down-converter that sits directly downstream of the skid buffer and consumes its down_data/down_valid/down_ready stream.
- Accepts one DW-bit word per handshake and emits it as RATIO = DW/OW consecutive OW-bit beats on a valid/ready interface.
- Marks the final beat of each word with down_last.
- Sustains full throughput (one beat per cycle) across word boundaries with no bubble.

Parameters:
- DW, 16, input word width in bits.
- OW, 4, output beat width in bits; DW must be an integer multiple of OW, otherwise elaboration fails.
- MSB_FIRST, 0, beat order: 0 = least-significant OW slice first; 1 = most-significant slice first.
- (derived, not overridable) RATIO = DW/OW; CW = max(1, clog2(RATIO)).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- up_data  in  DW  input word
- up_valid  in  1  input word valid
- up_ready  out  1  block can accept a word this cycle
- down_data  out  OW  current beat
- down_valid  out  1  beat valid
- down_last  out  1  current beat is the final slice of its word
- down_ready  in  1  downstream accepts beat

Behaviour:
- One clock; reset is synchronous and active-high.
- State:
  - busy flag (a word is being emitted).
  - beat counter cnt[CW-1:0].
  - shift register sreg[DW-1:0].
- Reset (rst high at a clock edge):
  - busy=0, cnt=0.
  - sreg is not reset (datapath only).
  - Outputs after reset: down_valid=0, down_last=0, up_ready=1; down_data is don't-care.
- Handshakes:
  - up_fire = up_valid & up_ready.
  - dn_fire = down_valid & down_ready.
- Output decode:
  - down_valid = busy.
  - down_last = busy & (cnt == RATIO-1).
  - down_data = sreg[OW-1:0] if MSB_FIRST=0, else sreg[DW-1:DW-OW].
- up_ready = ~busy | (down_last & down_ready).
  - This is combinational from down_ready, deliberately, to give zero-bubble word chaining.
  - The upstream skid buffer tolerates this path.
- Sequential update, in priority order:
  - up_fire: sreg<=up_data, cnt<=0, busy<=1. This also covers up_fire in the same cycle as the last-beat dn_fire, giving back-to-back words.
  - else dn_fire & down_last: busy<=0, cnt<=0.
  - else dn_fire: cnt<=cnt+1; sreg shifts by OW toward the output end (right for LSB-first, left for MSB-first); vacated bits are don't-care.
  - else: hold all state.
- Latency: a word accepted at edge N presents its first beat at cycle N+1. A word produces exactly RATIO beats.
- Stability: while down_valid=1 & down_ready=0, down_data and down_last hold constant.
- up_valid / up_data while busy and not on the last beat: ignored; up_ready=0.
- RATIO=1: block degenerates to a one-entry register stage. Every beat has down_last=1; full throughput is retained via the up_ready rule.
- cnt never exceeds RATIO-1; there is no wrap-around past the last beat.
- Reset mid-word: the partially emitted word is discarded and no further beats of it appear. up_ready=1 in the first cycle after reset.
- No X on down_valid/down_last/up_ready after reset regardless of input values.

Decomposition:
- Shared stream package: the beat-order constants (LSB_FIRST=0, MSB_FIRST=1) and the clog2-with-floor-1 helper used to compute CW.
- No sub-module. Counter, shift register and handshake logic are kept in one module of roughly 120-150 lines.

Test Plan:
- DW=16, OW=4, MSB_FIRST=0, down_ready=1; send 0xABCD.
  - Beats D, C, B, A on cycles N+1..N+4.
  - down_last=1 only on A.
  - up_ready=0 on cycles N+1..N+3 and 1 on N+4.
- Back-to-back words 0x1234 then 0x5678 with up_valid and down_ready held high.
  - Eight consecutive beats 4, 3, 2, 1, 8, 7, 6, 5 with no bubble.
  - Second up_fire occurs in the cycle of beat 1.
- Backpressure: send 0xABCD and drop down_ready for 3 cycles while beat C is presented.
  - C holds stable with down_valid=1, down_last=0.
  - Then B, A follow.
  - up_ready stays 0 throughout.
- MSB_FIRST=1; send 0xABCD → beats A, B, C, D, with down_last on D.
- Reset mid-word: assert rst for 1 cycle after beat D of 0xABCD.
  - down_valid=0 the next cycle and up_ready=1.
  - A subsequent word 0x00F1 emits 1, F, 0, 0 with no stale beats.
- RATIO=1 (DW=OW=8): stream 0x11, 0x22, 0x33 with down_ready toggling 1, 0, 1, 1.
  - Outputs appear in order, each with down_last=1.
  - No loss or duplication.

Source files
------------

// File: rtl/word_serializer_pkg.sv
// Shared stream definitions for the word serializer: beat-order selectors,
// state encoding and the counter-width helper.
package word_serializer_pkg;

   // Beat-order selectors for the MSB_FIRST parameter.
   localparam int unsigned BEAT_LSB_FIRST = 0;
   localparam int unsigned BEAT_MSB_FIRST = 1;

   // Emission state: idle (no word held) or emitting beats of a held word.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } ser_state_e;

   // Ceiling log2 with a floor of 1, so a single-beat counter still has one bit.
   function automatic int unsigned clog2_floor1(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/word_serializer.sv
// Width down-converter: accepts one DW-bit word per handshake and emits it as
// DW/OW consecutive OW-bit beats, flagging the final beat with down_last.
// up_ready is combinational from down_ready so a new word can be taken in the
// same cycle as the last beat leaves, giving bubble-free word chaining.
module word_serializer
   import word_serializer_pkg::*;
#(
   parameter int unsigned DW        = 16,
   parameter int unsigned OW        = 4,
   parameter int unsigned MSB_FIRST = BEAT_LSB_FIRST
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] up_data,
   input  logic          up_valid,
   output logic          up_ready,
   output logic [OW-1:0] down_data,
   output logic          down_valid,
   output logic          down_last,
   input  logic          down_ready
);

   localparam int unsigned RATIO = DW / OW;
   localparam int unsigned CW    = clog2_floor1(RATIO);
   localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

   if ((DW % OW) != 0) begin : g_bad_width
      $error("word_serializer: DW (%0d) must be an integer multiple of OW (%0d)", DW, OW);
   end

   ser_state_e    state;
   logic [CW-1:0] cnt;
   logic [DW-1:0] sreg;
   logic          busy;
   logic          up_fire;
   logic          dn_fire;

   assign busy       = (state == ST_EMIT);
   assign down_valid = busy;
   assign down_last  = busy && (cnt == LAST_CNT);
   assign up_ready   = !busy || (down_last && down_ready);
   assign up_fire    = up_valid && up_ready;
   assign dn_fire    = down_valid && down_ready;

   // The output slice always sits at the end of sreg that shifting moves toward.
   if (MSB_FIRST == BEAT_MSB_FIRST) begin : g_msb_out
      assign down_data = sreg[DW-1 -: OW];
   end else begin : g_lsb_out
      assign down_data = sreg[OW-1:0];
   end

   // Control: load on word accept, release after the last beat, else step the beat counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else if (up_fire) begin
         state <= ST_EMIT;
         cnt   <= '0;
      end else if (dn_fire && down_last) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else if (dn_fire) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Datapath: capture the accepted word, then shift one beat toward the output end per beat taken.
   always_ff @(posedge clk) begin
      if (up_fire) begin
         sreg <= up_data;
      end else if (dn_fire && !down_last) begin
         if (MSB_FIRST == BEAT_MSB_FIRST) begin
            sreg <= sreg << OW;
         end else begin
            sreg <= sreg >> OW;
         end
      end
   end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: LSB-first 16/4, MSB-first 16/4 and a
// single-beat 8/8 instance, each driven with hand-computed beat sequences.
module tb_word_serializer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Instance A: DW=16, OW=4, LSB first
   logic [15:0] a_ud;
   logic        a_uv, a_ur, a_dv, a_dl, a_dr;
   logic [3:0]  a_dd;
   // Instance B: DW=16, OW=4, MSB first
   logic [15:0] b_ud;
   logic        b_uv, b_ur, b_dv, b_dl, b_dr;
   logic [3:0]  b_dd;
   // Instance C: DW=8, OW=8 (single beat per word)
   logic [7:0]  c_ud;
   logic        c_uv, c_ur, c_dv, c_dl, c_dr;
   logic [7:0]  c_dd;

   word_serializer #(.DW(16), .OW(4), .MSB_FIRST(0)) u_a (
      .clk(clk), .rst(rst), .up_data(a_ud), .up_valid(a_uv), .up_ready(a_ur),
      .down_data(a_dd), .down_valid(a_dv), .down_last(a_dl), .down_ready(a_dr));

   word_serializer #(.DW(16), .OW(4), .MSB_FIRST(1)) u_b (
      .clk(clk), .rst(rst), .up_data(b_ud), .up_valid(b_uv), .up_ready(b_ur),
      .down_data(b_dd), .down_valid(b_dv), .down_last(b_dl), .down_ready(b_dr));

   word_serializer #(.DW(8), .OW(8), .MSB_FIRST(0)) u_c (
      .clk(clk), .rst(rst), .up_data(c_ud), .up_valid(c_uv), .up_ready(c_ur),
      .down_data(c_dd), .down_valid(c_dv), .down_last(c_dl), .down_ready(c_dr));

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // One cycle on instance sel: drive inputs, check outputs at the falling edge,
   // then advance past the next rising edge.
   task automatic cy(input int sel, input logic uv, input logic [15:0] ud, input logic dr,
                     input logic rs, input logic ev, input logic el, input logic [7:0] ed,
                     input logic eur, input string tag);
      logic       g_dv, g_dl, g_ur;
      logic [7:0] g_dd;
      a_uv = 1'b0; b_uv = 1'b0; c_uv = 1'b0;
      a_dr = 1'b1; b_dr = 1'b1; c_dr = 1'b1;
      rst = rs;
      case (sel)
         0: begin a_uv = uv; a_ud = ud; a_dr = dr; end
         1: begin b_uv = uv; b_ud = ud; b_dr = dr; end
         default: begin c_uv = uv; c_ud = ud[7:0]; c_dr = dr; end
      endcase
      @(negedge clk);
      case (sel)
         0: begin g_dv = a_dv; g_dl = a_dl; g_ur = a_ur; g_dd = {4'h0, a_dd}; end
         1: begin g_dv = b_dv; g_dl = b_dl; g_ur = b_ur; g_dd = {4'h0, b_dd}; end
         default: begin g_dv = c_dv; g_dl = c_dl; g_ur = c_ur; g_dd = c_dd; end
      endcase
      check({tag, ".valid"}, 32'(g_dv), 32'(ev));
      check({tag, ".last"}, 32'(g_dl), 32'(el));
      check({tag, ".up_ready"}, 32'(g_ur), 32'(eur));
      if (ev) check({tag, ".data"}, 32'(g_dd), 32'(ed));
      @(posedge clk);
      #1;
   endtask

   initial begin
      a_ud = '0; b_ud = '0; c_ud = '0;
      a_uv = 1'b0; b_uv = 1'b0; c_uv = 1'b0;
      a_dr = 1'b1; b_dr = 1'b1; c_dr = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Reset state on every instance
      cy(0, 0, 16'h0, 1, 0, 0, 0, 8'h0, 1, "rst_a");
      cy(1, 0, 16'h0, 1, 0, 0, 0, 8'h0, 1, "rst_b");
      cy(2, 0, 16'h0, 1, 0, 0, 0, 8'h0, 1, "rst_c");

      // Single word, LSB first: D C B A
      cy(0, 1, 16'hABCD, 1, 0, 0, 0, 8'h0, 1, "t1_acc");
      cy(0, 0, 16'h0,    1, 0, 1, 0, 8'hD, 0, "t1_b0");
      cy(0, 0, 16'h0,    1, 0, 1, 0, 8'hC, 0, "t1_b1");
      cy(0, 0, 16'h0,    1, 0, 1, 0, 8'hB, 0, "t1_b2");
      cy(0, 0, 16'h0,    1, 0, 1, 1, 8'hA, 1, "t1_b3");
      cy(0, 0, 16'h0,    1, 0, 0, 0, 8'h0, 1, "t1_idle");

      // Back-to-back words: 4 3 2 1 8 7 6 5, second accept on beat 1
      cy(0, 1, 16'h1234, 1, 0, 0, 0, 8'h0, 1, "t2_acc");
      cy(0, 1, 16'h5678, 1, 0, 1, 0, 8'h4, 0, "t2_b0");
      cy(0, 1, 16'h5678, 1, 0, 1, 0, 8'h3, 0, "t2_b1");
      cy(0, 1, 16'h5678, 1, 0, 1, 0, 8'h2, 0, "t2_b2");
      cy(0, 1, 16'h5678, 1, 0, 1, 1, 8'h1, 1, "t2_b3");
      cy(0, 0, 16'h0,    1, 0, 1, 0, 8'h8, 0, "t2_b4");
      cy(0, 0, 16'h0,    1, 0, 1, 0, 8'h7, 0, "t2_b5");
      cy(0, 0, 16'h0,    1, 0, 1, 0, 8'h6, 0, "t2_b6");
      cy(0, 0, 16'h0,    1, 0, 1, 1, 8'h5, 1, "t2_b7");
      cy(0, 0, 16'h0,    1, 0, 0, 0, 8'h0, 1, "t2_idle");

      // Backpressure on beat C for three cycles
      cy(0, 1, 16'hABCD, 1, 0, 0, 0, 8'h0, 1, "t3_acc");
      cy(0, 0, 16'h0,    1, 0, 1, 0, 8'hD, 0, "t3_b0");
      cy(0, 1, 16'h9999, 0, 0, 1, 0, 8'hC, 0, "t3_stall0");
      cy(0, 1, 16'h9999, 0, 0, 1, 0, 8'hC, 0, "t3_stall1");
      cy(0, 0, 16'h0,    0, 0, 1, 0, 8'hC, 0, "t3_stall2");
      cy(0, 0, 16'h0,    1, 0, 1, 0, 8'hC, 0, "t3_b1");
      cy(0, 0, 16'h0,    1, 0, 1, 0, 8'hB, 0, "t3_b2");
      cy(0, 0, 16'h0,    1, 0, 1, 1, 8'hA, 1, "t3_b3");
      cy(0, 0, 16'h0,    1, 0, 0, 0, 8'h0, 1, "t3_idle");

      // Reset mid-word, then a fresh word 0x00F1
      cy(0, 1, 16'hABCD, 1, 0, 0, 0, 8'h0, 1, "t4_acc");
      cy(0, 0, 16'h0,    1, 0, 1, 0, 8'hD, 0, "t4_b0");
      cy(0, 0, 16'h0,    1, 1, 1, 0, 8'hC, 0, "t4_rst");
      cy(0, 1, 16'h00F1, 1, 0, 0, 0, 8'h0, 1, "t4_after");
      cy(0, 0, 16'h0,    1, 0, 1, 0, 8'h1, 0, "t4_b0n");
      cy(0, 0, 16'h0,    1, 0, 1, 0, 8'hF, 0, "t4_b1n");
      cy(0, 0, 16'h0,    1, 0, 1, 0, 8'h0, 0, "t4_b2n");
      cy(0, 0, 16'h0,    1, 0, 1, 1, 8'h0, 1, "t4_b3n");
      cy(0, 0, 16'h0,    1, 0, 0, 0, 8'h0, 1, "t4_idle");

      // MSB first: A B C D
      cy(1, 1, 16'hABCD, 1, 0, 0, 0, 8'h0, 1, "t5_acc");
      cy(1, 0, 16'h0,    1, 0, 1, 0, 8'hA, 0, "t5_b0");
      cy(1, 0, 16'h0,    1, 0, 1, 0, 8'hB, 0, "t5_b1");
      cy(1, 0, 16'h0,    1, 0, 1, 0, 8'hC, 0, "t5_b2");
      cy(1, 0, 16'h0,    1, 0, 1, 1, 8'hD, 1, "t5_b3");
      cy(1, 0, 16'h0,    1, 0, 0, 0, 8'h0, 1, "t5_idle");

      // Single-beat words with down_ready 1,0,1,1
      cy(2, 1, 16'h0011, 1, 0, 0, 0, 8'h00, 1, "t6_acc");
      cy(2, 1, 16'h0022, 1, 0, 1, 1, 8'h11, 1, "t6_o0");
      cy(2, 1, 16'h0033, 0, 0, 1, 1, 8'h22, 0, "t6_o1");
      cy(2, 1, 16'h0033, 1, 0, 1, 1, 8'h22, 1, "t6_o2");
      cy(2, 0, 16'h0,    1, 0, 1, 1, 8'h33, 1, "t6_o3");
      cy(2, 0, 16'h0,    1, 0, 0, 0, 8'h00, 1, "t6_idle");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
